mdio_master: RTL and testbench

Parametrised MDIO management master that runs Clause 22 and Clause 45 frames to an external PHY. It takes the PHY address per command, has a configurable MDC divider and optional preamble suppression, and checks turnaround on reads. It sits between the MAC management/config logic and the PHY pins, and returns exactly one response per accepted command. The MDIO pin is split into o/oe/i so the top level owns the IOBUF.

---
 rtl/mdio_master.sv | 171 +++++++++++++++++
 tb/tb_mdio_master.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// MDIO management master: runs one Clause 22 / Clause 45 frame per accepted
// command and returns exactly one response. The MDIO pad is split into o/oe/i.
module mdio_master #(
  parameter int CLK_DIV      = 25,
  parameter int PREAMBLE_LEN = 32,
  parameter bit SUPPORT_C45  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_c45,
  input  logic [4:0]  cmd_phy_adr,
  input  logic [4:0]  cmd_reg_adr,
  input  logic [15:0] cmd_data,
  input  logic        preamble_suppress,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  // Handshakes (cmd and rsp): a transfer happens on a rising clk edge where
  // valid && ready; the offering side holds valid and its payload until then.

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_RESP} state_t;

  state_t           state, state_nxt;
  logic [5:0]       slot, slot_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       op_q;
  logic             c45_q;
  logic [4:0]       phy_q, reg_q;
  logic [15:0]      wdata_q, rd_q;
  logic [5:0]       pre_len_q, pre_len_cmd;
  logic             err_q;
  logic [1:0]       sync_q;
  logic             accept, c45_eff, illegal, framing, half_end, rise, slot_end, is_read;
  logic [13:0]      hdr;

  assign cmd_ready   = (state == S_IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign c45_eff     = SUPPORT_C45 && cmd_c45;
  assign illegal     = !c45_eff && (cmd_op == 2'b00 || cmd_op == 2'b11);
  assign pre_len_cmd = preamble_suppress ? 6'd0 : 6'(PREAMBLE_LEN);
  assign framing     = state inside {S_PRE, S_HDR, S_TA, S_DATA};
  assign half_end    = framing && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise        = half_end && !mdc;
  assign slot_end    = half_end && mdc;
  assign is_read     = op_q[1];
  assign hdr         = {1'b0, !c45_q, op_q, phy_q, reg_q};

  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_data  = rd_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    unique case (state)
      S_IDLE: if (accept) begin
        slot_nxt = '0;
        if (illegal)                  state_nxt = S_RESP;
        else if (pre_len_cmd == 6'd0) state_nxt = S_HDR;
        else                          state_nxt = S_PRE;
      end
      S_PRE: if (slot_end) begin
        if (slot == pre_len_q - 6'd1) begin state_nxt = S_HDR; slot_nxt = '0; end
        else slot_nxt = slot + 6'd1;
      end
      S_HDR: if (slot_end) begin
        if (slot == 6'd13) begin state_nxt = S_TA; slot_nxt = '0; end
        else slot_nxt = slot + 6'd1;
      end
      S_TA: if (slot_end) begin
        if (slot == 6'd1) begin state_nxt = S_DATA; slot_nxt = '0; end
        else slot_nxt = slot + 6'd1;
      end
      S_DATA: if (slot_end) begin
        if (slot == 6'd15) begin state_nxt = S_RESP; slot_nxt = '0; end
        else slot_nxt = slot + 6'd1;
      end
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pad drive is a pure decode of the slot position, so it only changes at slot starts.
  always_comb begin
    mdio_o  = 1'b1;
    mdio_oe = 1'b0;
    unique case (state)
      S_PRE: mdio_oe = 1'b1;
      S_HDR: begin
        mdio_oe = 1'b1;
        mdio_o  = hdr[4'd13 - slot[3:0]];
      end
      S_TA: if (!is_read) begin
        mdio_oe = 1'b1;
        mdio_o  = (slot[0] == 1'b0);
      end
      S_DATA: if (!is_read) begin
        mdio_oe = 1'b1;
        mdio_o  = wdata_q[4'd15 - slot[3:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt   <= '0;
      mdc       <= 1'b0;
      op_q      <= '0;
      c45_q     <= 1'b0;
      phy_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      pre_len_q <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      sync_q    <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], mdio_i};
      if (accept) begin
        div_cnt   <= '0;
        mdc       <= 1'b0;
        op_q      <= cmd_op;
        c45_q     <= c45_eff;
        phy_q     <= cmd_phy_adr;
        reg_q     <= cmd_reg_adr;
        wdata_q   <= cmd_data;
        pre_len_q <= pre_len_cmd;
        rd_q      <= '0;
        err_q     <= illegal;
      end else if (framing) begin
        if (half_end) begin
          div_cnt <= '0;
          mdc     <= !mdc;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        // The PHY's bit has been stable for a full half-period when mdc rises.
        if (rise && is_read) begin
          if (state == S_TA && slot == 6'd1) err_q <= err_q | sync_q[1];
          if (state == S_DATA)               rd_q  <= {rd_q[14:0], sync_q[1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: a slot-level frame model predicts the pins every cycle,
// a PHY model answers reads, and directed frames pin the model with literals.
module tb_mdio_master;

  localparam int D      = 25;
  localparam int PL     = 32;
  localparam int M_IDLE = 0;
  localparam int M_FRAME = 1;
  localparam int M_RESP = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic        cmd_c45 = 1'b0;
  logic [4:0]  cmd_phy_adr = '0;
  logic [4:0]  cmd_reg_adr = '0;
  logic [15:0] cmd_data = '0;
  logic        preamble_suppress = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_i = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(PL), .SUPPORT_C45(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_c45(cmd_c45),
    .cmd_phy_adr(cmd_phy_adr), .cmd_reg_adr(cmd_reg_adr), .cmd_data(cmd_data),
    .preamble_suppress(preamble_suppress),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  // PHY behaviour for the next command, latched by the model at accept.
  logic        ph_present = 1'b0;
  logic        ph_ta2 = 1'b0;
  logic [15:0] ph_word = '0;

  int          m_mode = M_IDLE;
  int          m_cyc = 0, m_len = 0, m_p = 0, acc_cyc = 0, n_acc = 0;
  logic [63:0] m_o = '1, m_oe = '0;
  logic        m_rd = 1'b0, m_present = 1'b0, m_ta2 = 1'b0;
  logic [15:0] m_word = '0;
  logic [16:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, expected event (cycle %0d)", name, cyc);
  endtask

  function automatic int pre_bits(input logic supp);
    return supp ? 0 : PL;
  endfunction

  function automatic logic is_illegal(input logic [1:0] op, input logic c45);
    return !c45 && (op == 2'b00 || op == 2'b11);
  endfunction

  // Whole frame as a bit string, slot i at bit i: preamble, ST, OP, PHYAD, REGAD, TA, DATA.
  function automatic logic [63:0] frame_o(input logic [1:0] op, input logic c45, input logic [4:0] pa,
                                          input logic [4:0] ra, input logic [15:0] d, input int p);
    logic [31:0] body;
    logic [63:0] v;
    body = {1'b0, !c45, op, pa, ra, (op[1] ? 2'b11 : 2'b10), (op[1] ? 16'hFFFF : d)};
    v = '1;
    for (int i = p; i < p + 32; i++) v[i] = body[31 - (i - p)];
    return v;
  endfunction

  function automatic logic [63:0] frame_oe(input logic [1:0] op, input int p);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < p + 32; i++) v[i] = !(op[1] && i >= p + 14);
    return v;
  endfunction

  function automatic logic [16:0] exp_rsp(input logic ill, input logic rd, input logic present,
                                          input logic ta2, input logic [15:0] word);
    if (ill) return 17'h10000;
    if (!rd) return 17'h00000;
    if (present) return {ta2, word};
    return 17'h1FFFF;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_mode <= M_IDLE;
      m_cyc  <= 0;
      exp_q.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (cmd_valid) begin
          m_o       <= frame_o(cmd_op, cmd_c45, cmd_phy_adr, cmd_reg_adr, cmd_data, pre_bits(preamble_suppress));
          m_oe      <= frame_oe(cmd_op, pre_bits(preamble_suppress));
          m_p       <= pre_bits(preamble_suppress);
          m_len     <= (pre_bits(preamble_suppress) + 32) * 2 * D;
          m_cyc     <= 1;
          m_rd      <= !is_illegal(cmd_op, cmd_c45) && cmd_op[1];
          m_present <= ph_present;
          m_ta2     <= ph_ta2;
          m_word    <= ph_word;
          exp_q.push_back(exp_rsp(is_illegal(cmd_op, cmd_c45), cmd_op[1], ph_present, ph_ta2, ph_word));
          acc_cyc   <= cyc;
          n_acc     <= n_acc + 1;
          m_mode    <= is_illegal(cmd_op, cmd_c45) ? M_RESP : M_FRAME;
        end
        M_FRAME: begin
          if (m_cyc == m_len) m_mode <= M_RESP;
          else                m_cyc  <= m_cyc + 1;
        end
        M_RESP: if (rsp_ready) begin
          void'(exp_q.pop_front());
          m_mode <= M_IDLE;
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  // PHY: drives TA2 and the data bits from the start of their slots; idle line is pulled up.
  function automatic logic phy_bit(input int c);
    int s;
    s = (c - 1) / (2 * D);
    if (!m_present) return 1'b1;
    if (s == m_p + 15) return m_ta2;
    if (s >= m_p + 16 && s < m_p + 32) return m_word[15 - (s - m_p - 16)];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    #2;
    mdio_i = (m_mode == M_FRAME && m_rd) ? phy_bit(m_cyc) : 1'b1;
  end

  logic        mdc_prev = 1'b0, rv_prev = 1'b0;
  int          seen_acc = 0, n_rises = 0, rsp_lat = -1;
  logic [63:0] cap_bits = '0;
  logic [16:0] last_rsp = '0;

  always @(negedge clk) begin
    int s, ph;
    logic [5:0] ex;
    s  = (m_cyc - 1) / (2 * D);
    ph = (m_cyc - 1) % (2 * D);
    case (m_mode)
      M_FRAME: ex = {3'b010, (ph >= D), m_o[s], m_oe[s]};
      M_RESP:  ex = 6'b011010;
      default: ex = 6'b100010;
    endcase
    check("pins{ready,busy,valid,mdc,o,oe}", 64'({cmd_ready, busy, rsp_valid, mdc, mdio_o, mdio_oe}), 64'(ex));
    if (m_mode == M_RESP)
      check("rsp{err,data}", 64'({rsp_err, rsp_data}), 64'(exp_q.size() > 0 ? exp_q[0] : 17'h1FFFF));
    if (seen_acc != n_acc) begin
      seen_acc = n_acc;
      n_rises  = 0;
      cap_bits = '0;
    end
    if (mdc && !mdc_prev) begin
      n_rises++;
      cap_bits = {cap_bits[62:0], mdio_o};
    end
    if (rsp_valid && !rv_prev) rsp_lat = cyc - acc_cyc;
    if (rsp_valid) last_rsp = {rsp_err, rsp_data};
    mdc_prev = mdc;
    rv_prev  = rsp_valid;
  end

  task automatic send(input logic [1:0] op, input logic c45, input logic [4:0] pa, input logic [4:0] ra,
                      input logic [15:0] d, input logic supp, input logic present, input logic ta2,
                      input logic [15:0] word);
    int k;
    k = 0;
    @(negedge clk);
    while (m_mode != M_IDLE && k < 10000) begin
      @(negedge clk);
      k++;
    end
    if (m_mode != M_IDLE) begin
      timeout("send_wait_idle");
      return;
    end
    cmd_op = op; cmd_c45 = c45; cmd_phy_adr = pa; cmd_reg_adr = ra; cmd_data = d;
    preamble_suppress = supp;
    ph_present = present; ph_ta2 = ta2; ph_word = word;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_c45 = 1'($urandom); cmd_phy_adr = 5'($urandom);
    cmd_reg_adr = 5'($urandom); cmd_data = 16'($urandom); preamble_suppress = 1'($urandom);
  endtask

  task automatic wait_mode(input int mode, input string name);
    int k;
    k = 0;
    while (m_mode != mode && k < 10000) begin
      @(negedge clk);
      k++;
    end
    if (m_mode != mode) timeout(name);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!(m_mode == M_IDLE && exp_q.size() == 0) && k < 10000) begin
      @(negedge clk);
      k++;
    end
    if (!(m_mode == M_IDLE && exp_q.size() == 0)) timeout("wait_done");
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("reset_rsp_data", 64'(rsp_data), 64'h0);
    check("reset_rsp_err", 64'(rsp_err), 64'h0);
    check("reset_pins", 64'({cmd_ready, busy, rsp_valid, mdc, mdio_o, mdio_oe}), 64'b100010);

    // C22 write with full preamble; latency counted from the accept cycle T.
    send(2'b01, 1'b0, 5'h01, 5'h04, 16'h01E1, 1'b0, 1'b0, 1'b0, 16'h0);
    wait_done();
    check("c22_wr_bits", cap_bits, 64'hFFFFFFFF_509201E1);
    check("c22_wr_rises", 64'(n_rises), 64'd64);
    check("c22_wr_latency", 64'(rsp_lat), 64'd3201);
    check("c22_wr_rsp", 64'(last_rsp), 64'h0);

    send(2'b10, 1'b0, 5'h01, 5'h01, 16'h0, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    wait_done();
    check("c22_rd_bits", cap_bits, 64'hFFFFFFFF_6087FFFF);
    check("c22_rd_rsp", 64'(last_rsp), 64'h0BEEF);

    send(2'b10, 1'b0, 5'h07, 5'h02, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_done();
    check("nophy_rsp", 64'(last_rsp), 64'h1FFFF);
    check("nophy_rises", 64'(n_rises), 64'd32);

    send(2'b00, 1'b1, 5'h03, 5'h01, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_done();
    check("c45_adr_bits", 64'(cap_bits[31:0]), 64'h01861234);
    check("c45_adr_rises", 64'(n_rises), 64'd32);
    check("c45_adr_latency", 64'(rsp_lat), 64'd1601);
    check("c45_adr_rsp", 64'(last_rsp), 64'h0);

    send(2'b11, 1'b1, 5'h03, 5'h01, 16'h0, 1'b1, 1'b1, 1'b0, 16'h5678);
    wait_done();
    check("c45_rd_bits", 64'(cap_bits[31:0]), 64'h3187FFFF);
    check("c45_rd_rises", 64'(n_rises), 64'd32);
    check("c45_rd_rsp", 64'(last_rsp), 64'h05678);

    // Illegal C22 op held under response backpressure for 100 cycles.
    rsp_ready = 1'b0;
    send(2'b00, 1'b0, 5'h01, 5'h01, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0);
    wait_mode(M_RESP, "illegal_wait_resp");
    repeat (100) @(negedge clk);
    check("illegal_rises", 64'(n_rises), 64'd0);
    check("illegal_latency", 64'(rsp_lat), 64'd1);
    check("illegal_rsp", 64'(last_rsp), 64'h10000);
    rsp_ready = 1'b1;
    wait_done();

    // Reset in slot 40 of a read, with mdc high.
    send(2'b10, 1'b0, 5'h05, 5'h09, 16'h0, 1'b0, 1'b1, 1'b0, 16'($urandom));
    begin
      int k;
      k = 0;
      while (!(m_mode == M_FRAME && m_cyc == 40 * 2 * D + 31) && k < 10000) begin
        @(negedge clk);
        k++;
      end
      if (!(m_mode == M_FRAME && m_cyc == 40 * 2 * D + 31)) timeout("reset_wait_slot40");
    end
    check("pre_reset_mdc", 64'(mdc), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("reset_mid_mdc", 64'(mdc), 64'd0);
    check("reset_mid_oe", 64'(mdio_oe), 64'd0);
    check("reset_mid_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 64'(cmd_ready), 64'd1);
    check("post_reset_valid", 64'(rsp_valid), 64'd0);
    send(2'b01, 1'b0, 5'h02, 5'h00, 16'hA5A5, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_done();
    check("post_reset_wr_bits", 64'(cap_bits[31:0]), 64'h5102A5A5);
    check("post_reset_wr_rsp", 64'(last_rsp), 64'h0);

    // Randomized commands, including illegal C22 ops and response backpressure.
    for (int i = 0; i < 10; i++) begin
      logic present;
      logic hold;
      present = 1'($urandom);
      hold    = 1'($urandom);
      rsp_ready = !hold;
      send(2'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'($urandom),
           present, present && ($urandom_range(0, 3) == 0), 16'($urandom));
      if (hold) begin
        wait_mode(M_RESP, "rand_wait_resp");
        repeat ($urandom_range(1, 20)) @(negedge clk);
        rsp_ready = 1'b1;
      end
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
